adder_share_arbiter: RTL

Shares one 32-bit adder datapath between two requesters, e.g. PC-increment and branch-target calculation in a multi-cycle CPU. Arbitration is round-robin, with a valid/ready handshake on both the request and response sides. Operands and results are registered. The result is a true modulo-2^WIDTH sum with carry and signed-overflow flags.

---
 rtl/adder_share_pkg.sv | 17 +
 rtl/adder_cout.sv | 18 +
 rtl/adder_share_arbiter.sv | 126 ++++++++++++
 3 files changed

// File: rtl/adder_share_pkg.sv
// Shared types and constants for the two-requester shared adder.
package adder_share_pkg;

  localparam int unsigned WIDTH_DEFAULT = 32;
  localparam int unsigned ID_W_DEFAULT  = 1;

  // Requester identifiers
  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/adder_cout.sv
// Combinational WIDTH-bit adder, carry-in 0, full carry chain to carry-out.
module adder_cout #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH:0] full;

  // One extra bit holds the carry out of the MSB
  assign full = {1'b0, a} + {1'b0, b};
  assign sum  = full[WIDTH-1:0];
  assign cout = full[WIDTH];

endmodule

// File: rtl/adder_share_arbiter.sv
// One registered adder shared round-robin between two valid/ready requesters.
module adder_share_arbiter
  import adder_share_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT,
  parameter int unsigned ID_W  = ID_W_DEFAULT
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req0_valid_i,
  input  logic [WIDTH-1:0] req0_src1_i,
  input  logic [WIDTH-1:0] req0_src2_i,
  output logic             req0_ready_o,
  input  logic             req1_valid_i,
  input  logic [WIDTH-1:0] req1_src1_i,
  input  logic [WIDTH-1:0] req1_src2_i,
  output logic             req1_ready_o,
  output logic             resp_valid_o,
  output logic [ID_W-1:0]  resp_id_o,
  input  logic             resp_ready_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             carry_o,
  output logic             ovf_o,
  output logic             busy_o
);

  localparam int unsigned MSB = WIDTH - 1;

  state_t           state_q, state_d;
  logic             last_gnt_q;
  logic [ID_W-1:0]  id_q;
  logic [WIDTH-1:0] src1_q, src2_q;
  logic             resp_valid_q;
  logic [ID_W-1:0]  resp_id_q;
  logic [WIDTH-1:0] sum_q;
  logic             carry_q, ovf_q;
  logic             gnt0, gnt1;
  logic [WIDTH-1:0] add_sum;
  logic             add_cout;

  adder_cout #(
    .WIDTH (WIDTH)
  ) u_adder (
    .a    (src1_q),
    .b    (src2_q),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // State register
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state and round-robin grant; grants only exist in IDLE
  always_comb begin
    state_d = state_q;
    gnt0    = 1'b0;
    gnt1    = 1'b0;
    case (state_q)
      IDLE: begin
        if (req0_valid_i && req1_valid_i) begin
          gnt0 = (last_gnt_q == REQ1);
          gnt1 = (last_gnt_q == REQ0);
        end else begin
          gnt0 = req0_valid_i;
          gnt1 = req1_valid_i;
        end
        if (gnt0 || gnt1) state_d = EXEC;
      end
      EXEC:    state_d = RESP;
      RESP:    if (resp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand capture on grant; last_gnt starts at REQ1 so the first tie goes to req0
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      src1_q     <= '0;
      src2_q     <= '0;
      id_q       <= '0;
      last_gnt_q <= REQ1;
    end else if (gnt0) begin
      src1_q     <= req0_src1_i;
      src2_q     <= req0_src2_i;
      id_q       <= ID_W'(REQ0);
      last_gnt_q <= REQ0;
    end else if (gnt1) begin
      src1_q     <= req1_src1_i;
      src2_q     <= req1_src2_i;
      id_q       <= ID_W'(REQ1);
      last_gnt_q <= REQ1;
    end
  end

  // Result registers: load in EXEC, hold through RESP and afterwards
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      resp_valid_q <= 1'b0;
      resp_id_q    <= '0;
      sum_q        <= '0;
      carry_q      <= 1'b0;
      ovf_q        <= 1'b0;
    end else if (state_q == EXEC) begin
      resp_valid_q <= 1'b1;
      resp_id_q    <= id_q;
      sum_q        <= add_sum;
      carry_q      <= add_cout;
      ovf_q        <= (src1_q[MSB] == src2_q[MSB]) && (add_sum[MSB] != src1_q[MSB]);
    end else if (state_q == RESP && resp_ready_i) begin
      resp_valid_q <= 1'b0;
    end
  end

  assign req0_ready_o = gnt0;
  assign req1_ready_o = gnt1;
  assign resp_valid_o = resp_valid_q;
  assign resp_id_o    = resp_id_q;
  assign sum_o        = sum_q;
  assign carry_o      = carry_q;
  assign ovf_o        = ovf_q;
  assign busy_o       = (state_q != IDLE);

endmodule
